dmem_lsu: RTL

Load/store unit that acts as the initiator for the byte-addressed, little-endian data memory (D_MEM). The memory has a combinational word read and a synchronous word write. This unit sits between the execute stage and D_MEM.
- Accepts byte, halfword and word loads and stores from the pipeline.
- Performs lane extraction with sign or zero extension for loads.
- Performs read-modify-write for sub-word stores, because D_MEM only writes whole words.
- Reports misaligned and out-of-range accesses as errors.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_lane.sv | 45 ++++
 rtl/dmem_lsu.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the data-memory load/store unit.
package lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   localparam int unsigned MEM_BYTES_DEF = 512;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LD     = 3'd1,
      ST     = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4,
      RESP   = 3'd5
   } lsu_state_t;

endpackage

// File: rtl/lsu_lane.sv
// Byte/half lane extraction with sign or zero extension for loads, and lane merge for
// sub-word stores into a full memory word.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] load_val,
   output logic [31:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{lane, 3'b000} +: 8];
   assign half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      load_val = '0;
      merged   = rdata;
      case (size)
         SIZE_B: begin
            load_val = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SIZE_H: begin
            load_val = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            if (lane[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
         end
         SIZE_W: begin
            load_val = rdata;
            merged   = wdata;
         end
         default: begin
            load_val = '0;
            merged   = rdata;
         end
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide data memory; sub-word stores are done as
// read-modify-write since the memory only writes whole words.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   lsu_state_t        state_q, state_d;
   logic [1:0]        size_q;
   logic              uns_q;
   logic [1:0]        lane_q;
   logic [31:0]       wdata_q;
   logic              err_q;
   logic [31:0]       rdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;

   logic              accept;
   logic              req_err;
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       load_val;
   logic [31:0]       merged;

   assign accept    = (state_q == IDLE) && req_valid;
   assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SIZE_B:  req_err = 1'b0;
         SIZE_H:  req_err = req_addr[0];
         SIZE_W:  req_err = |req_addr[1:0];
         default: req_err = 1'b1;
      endcase
      if (word_addr > ADDR_W'(MEM_BYTES - 4)) req_err = 1'b1;
   end

   lsu_lane u_lane (
      .rdata       (mem_rdata),
      .wdata       (wdata_q),
      .lane        (lane_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .load_val    (load_val),
      .merged      (merged)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (req_err)              state_d = RESP;
               else if (!req_we)         state_d = LD;
               else if (req_size == SIZE_W) state_d = ST;
               else                      state_d = RMW_RD;
            end
         end
         LD:      state_d = RESP;
         ST:      state_d = RESP;
         RMW_RD:  state_d = RMW_WR;
         RMW_WR:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         size_q      <= '0;
         uns_q       <= 1'b0;
         lane_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
            // Memory-side outputs only move for requests that will touch memory.
            if (!req_err) mem_addr_q <= word_addr;
            if (!req_err && req_we && (req_size == SIZE_W)) mem_wdata_q <= req_wdata;
         end
         if (state_q == LD)     rdata_q     <= load_val;
         if (state_q == RMW_RD) mem_wdata_q <= merged;
      end
   end

   // Reset gates the strobes combinationally so nothing commits on the reset edge.
   assign req_ready  = !rst && (state_q == IDLE);
   assign mem_read   = !rst && ((state_q == LD) || (state_q == RMW_RD));
   assign mem_write  = !rst && ((state_q == ST) || (state_q == RMW_WR));
   assign resp_valid = !rst && (state_q == RESP);
   assign resp_err   = !rst && (state_q == RESP) && err_q;
   assign resp_rdata = rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
